// File: rtl/pb_mailbox_if.sv
// One side of the mailbox as seen by a port-mapped processor.
// The processor drives as master; the mailbox responds as slave.
interface pb_mailbox_if #(
  parameter int DATA_W = 8
) ();
  logic [7:0]        port_id;
  logic [DATA_W-1:0] out_port;
  logic              write_strobe;
  logic              read_strobe;
  logic [DATA_W-1:0] in_port;
  logic              interrupt;
  logic              interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );
  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pb_mailbox.sv
// Bidirectional mailbox between two port-mapped processors.
// It has one FIFO per direction and a register block per side.
module pb_mailbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     push_ok,
  output logic                     pop_ok,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the other side pops at the same edge
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk)
    if (push_ok && !reset) mem[wr_ptr] <= push_data;
endmodule

module pb_mailbox_side #(
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 4,
  parameter logic [7:0]  BASE   = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [DATA_W-1:0]      out_port,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic                   interrupt_ack,
  output logic [DATA_W-1:0]      in_port,
  output logic                   interrupt,
  output logic                   tx_push,
  output logic                   rx_pop,
  input  logic                   tx_push_ok,
  input  logic                   tx_full,
  input  logic                   rx_pop_ok,
  input  logic                   rx_push_ok,
  input  logic                   rx_empty,
  input  logic [DATA_W-1:0]      rx_head,
  input  logic [$clog2(DEPTH):0] rx_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              sel, wr_ctrl, irq_en, tx_ovf, rx_unf, irq_set;
  logic [1:0]        off;
  logic [CW+2:0]     cnt_ext;
  logic [2:0]        cnt_sat;
  logic [DATA_W-1:0] status, rd_next;

  assign sel     = (port_id[7:2] == BASE[7:2]);
  assign off     = port_id[1:0];
  assign tx_push = sel && write_strobe && (off == 2'd0);
  assign rx_pop  = sel && read_strobe  && (off == 2'd0);
  assign wr_ctrl = sel && write_strobe && (off == 2'd2);
  assign irq_set = (rx_push_ok && irq_en) || (wr_ctrl && out_port[0] && !rx_empty);

  always_comb begin
    cnt_ext     = {3'b000, rx_count};
    cnt_sat     = (cnt_ext > (CW+3)'(7)) ? 3'd7 : cnt_ext[2:0];
    status      = '0;
    status[7:0] = {1'b0, cnt_sat, rx_unf, tx_ovf, tx_full, !rx_empty};
    rd_next     = '0;
    if (sel) begin
      case (off)
        2'd0:    if (!rx_empty) rd_next = rx_head;
        2'd1:    rd_next = status;
        2'd2:    rd_next[0] = irq_en;
        default: rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port   <= '0;
      irq_en    <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      in_port <= rd_next;
      if (wr_ctrl) irq_en <= out_port[0];
      if (wr_ctrl && out_port[1])     tx_ovf <= 1'b0;
      else if (tx_push && !tx_push_ok) tx_ovf <= 1'b1;
      if (wr_ctrl && out_port[1])     rx_unf <= 1'b0;
      else if (rx_pop && !rx_pop_ok)   rx_unf <= 1'b1;
      // A new request beats an acknowledge arriving on the same edge
      if (irq_set)            interrupt <= 1'b1;
      else if (interrupt_ack) interrupt <= 1'b0;
    end
  end
endmodule

module pb_mailbox #(
  parameter int         DATA_W = 8,
  parameter int         DEPTH  = 4,
  parameter logic [7:0] BASE   = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  pb_mailbox_if.slave  a,
  pb_mailbox_if.slave  b
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              ab_push, ab_pop, ab_push_ok, ab_pop_ok, ab_empty, ab_full;
  logic              ba_push, ba_pop, ba_push_ok, ba_pop_ok, ba_empty, ba_full;
  logic [DATA_W-1:0] ab_head, ba_head;
  logic [CW-1:0]     ab_count, ba_count;

  pb_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ab (
    .clk(clk), .reset(reset), .push(ab_push), .push_data(a.out_port), .pop(ab_pop),
    .push_ok(ab_push_ok), .pop_ok(ab_pop_ok), .head(ab_head), .count(ab_count),
    .empty(ab_empty), .full(ab_full));

  pb_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ba (
    .clk(clk), .reset(reset), .push(ba_push), .push_data(b.out_port), .pop(ba_pop),
    .push_ok(ba_push_ok), .pop_ok(ba_pop_ok), .head(ba_head), .count(ba_count),
    .empty(ba_empty), .full(ba_full));

  pb_mailbox_side #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE)) u_a (
    .clk(clk), .reset(reset), .port_id(a.port_id), .out_port(a.out_port),
    .write_strobe(a.write_strobe), .read_strobe(a.read_strobe),
    .interrupt_ack(a.interrupt_ack), .in_port(a.in_port), .interrupt(a.interrupt),
    .tx_push(ab_push), .rx_pop(ba_pop), .tx_push_ok(ab_push_ok), .tx_full(ab_full),
    .rx_pop_ok(ba_pop_ok), .rx_push_ok(ba_push_ok), .rx_empty(ba_empty),
    .rx_head(ba_head), .rx_count(ba_count));

  pb_mailbox_side #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE)) u_b (
    .clk(clk), .reset(reset), .port_id(b.port_id), .out_port(b.out_port),
    .write_strobe(b.write_strobe), .read_strobe(b.read_strobe),
    .interrupt_ack(b.interrupt_ack), .in_port(b.in_port), .interrupt(b.interrupt),
    .tx_push(ba_push), .rx_pop(ab_pop), .tx_push_ok(ba_push_ok), .tx_full(ba_full),
    .rx_pop_ok(ab_pop_ok), .rx_push_ok(ab_push_ok), .rx_empty(ab_empty),
    .rx_head(ab_head), .rx_count(ab_count));
endmodule

// File: tb/tb_pb_mailbox.sv
// Directed and random bench for pb_mailbox against a queue-based reference model.
// Side index 0 is A, 1 is B; rxq[s] holds the words waiting for side s.
module tb_pb_mailbox;
  localparam int         DW    = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'h41;
  localparam logic [7:0] DAT = 8'h40, STA = 8'h41, CTL = 8'h42, RSV = 8'h43, OFF = 8'h10;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] d;
    logic       we;
    logic       re;
    logic       ack;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pb_mailbox_if #(.DATA_W(DW)) a_if ();
  pb_mailbox_if #(.DATA_W(DW)) b_if ();

  pb_mailbox #(.DATA_W(DW), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .a(a_if), .b(b_if));

  int tests = 0;
  int fails = 0;

  logic [7:0] rxq [2][$];
  logic       irq_en [2];
  logic       ovf [2];
  logic       unf [2];
  logic       intr [2];

  function automatic op_t mk(logic [7:0] id, logic we, logic re, logic [7:0] d, logic ack);
    op_t o;
    o.id = id; o.we = we; o.re = re; o.d = d; o.ack = ack;
    return o;
  endfunction

  function automatic op_t idle();
    return mk(OFF, 1'b0, 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic logic sel(logic [7:0] id);
    return id[7:2] == BASE[7:2];
  endfunction

  // What a side should see on in_port one edge after presenting id
  function automatic logic [7:0] model_read(int s, logic [7:0] id);
    int n;
    int sat;
    n = rxq[s].size();
    sat = (n > 7) ? 7 : n;
    if (!sel(id)) return 8'h00;
    case (id[1:0])
      2'd0:    return (n != 0) ? rxq[s][0] : 8'h00;
      2'd1:    return {1'b0, 3'(sat), unf[s], ovf[s], rxq[1-s].size() == DEPTH, n != 0};
      2'd2:    return {7'b0, irq_en[s]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(op_t a, op_t b);
    a_if.port_id = a.id; a_if.out_port = a.d; a_if.write_strobe = a.we;
    a_if.read_strobe = a.re; a_if.interrupt_ack = a.ack;
    b_if.port_id = b.id; b_if.out_port = b.d; b_if.write_strobe = b.we;
    b_if.read_strobe = b.re; b_if.interrupt_ack = b.ack;
  endtask

  task automatic step(op_t a, op_t b);
    op_t        o [2];
    logic [7:0] exp_in [2];
    int         n [2];
    logic       old_en [2];
    logic       pushed [2];
    o[0] = a; o[1] = b;
    @(negedge clk);
    reset = 1'b0;
    drive(a, b);
    for (int s = 0; s < 2; s++) begin
      exp_in[s] = model_read(s, o[s].id);
      n[s]      = rxq[s].size();
      old_en[s] = irq_en[s];
    end
    // t writes into the queue read by r = 1-t
    for (int t = 0; t < 2; t++) begin
      int   r;
      logic wd, rd, pop_ok, push_ok;
      r       = 1 - t;
      wd      = sel(o[t].id) && o[t].we && o[t].id[1:0] == 2'd0;
      rd      = sel(o[r].id) && o[r].re && o[r].id[1:0] == 2'd0;
      pop_ok  = rd && n[r] > 0;
      push_ok = wd && (n[r] < DEPTH || pop_ok);
      if (pop_ok)  void'(rxq[r].pop_front());
      if (push_ok) rxq[r].push_back(o[t].d);
      if (wd && !push_ok) ovf[t] = 1'b1;
      if (rd && !pop_ok)  unf[r] = 1'b1;
      pushed[r] = push_ok;
    end
    for (int s = 0; s < 2; s++) begin
      logic wc;
      wc = sel(o[s].id) && o[s].we && o[s].id[1:0] == 2'd2;
      if (wc) begin
        irq_en[s] = o[s].d[0];
        if (o[s].d[1]) begin ovf[s] = 1'b0; unf[s] = 1'b0; end
      end
      if ((pushed[s] && old_en[s]) || (wc && o[s].d[0] && n[s] > 0)) intr[s] = 1'b1;
      else if (o[s].ack) intr[s] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("a_in_port", a_if.in_port, exp_in[0]);
    check("b_in_port", b_if.in_port, exp_in[1]);
    check("a_interrupt", {7'b0, a_if.interrupt}, {7'b0, intr[0]});
    check("b_interrupt", {7'b0, b_if.interrupt}, {7'b0, intr[1]});
  endtask

  // Reset with live strobes; they must have no effect
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(mk(DAT, 1'b1, 1'b0, 8'h77, 1'b0), mk(DAT, 1'b0, 1'b1, 8'h00, 1'b1));
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      rxq[s].delete();
      irq_en[s] = 1'b0; ovf[s] = 1'b0; unf[s] = 1'b0; intr[s] = 1'b0;
    end
    check("rst_a_in_port", a_if.in_port, 8'h00);
    check("rst_b_in_port", b_if.in_port, 8'h00);
    check("rst_a_interrupt", {7'b0, a_if.interrupt}, 8'h00);
    check("rst_b_interrupt", {7'b0, b_if.interrupt}, 8'h00);
  endtask

  logic [7:0] ids [6] = '{DAT, DAT, STA, CTL, RSV, OFF};

  initial begin
    drive(idle(), idle());
    do_reset();

    // Interrupt on push, status with one word, drain
    step(idle(), mk(CTL, 1, 0, 8'h01, 0));
    step(mk(DAT, 1, 0, 8'h5A, 0), idle());
    check("r032_b_irq", {7'b0, b_if.interrupt}, 8'h01);
    step(idle(), mk(STA, 0, 0, 8'h00, 0));
    check("r032_b_status", b_if.in_port, 8'h11);
    step(idle(), mk(DAT, 0, 1, 8'h00, 0));
    check("r032_b_data", b_if.in_port, 8'h5A);
    step(idle(), mk(STA, 0, 0, 8'h00, 0));
    check("r032_b_status_after", b_if.in_port, 8'h00);
    step(idle(), mk(OFF, 0, 0, 8'h00, 1));

    // Overflow and underflow
    do_reset();
    for (int i = 1; i <= 5; i++) step(mk(DAT, 1, 0, 8'(i), 0), idle());
    step(mk(STA, 0, 0, 8'h00, 0), idle());
    check("r033_a_status", a_if.in_port, 8'h06);
    for (int i = 1; i <= 4; i++) begin
      step(idle(), mk(DAT, 0, 1, 8'h00, 0));
      check("r033_b_drain", b_if.in_port, 8'(i));
    end
    step(idle(), mk(DAT, 0, 1, 8'h00, 0));
    check("r033_b_empty_read", b_if.in_port, 8'h00);
    step(idle(), mk(STA, 0, 0, 8'h00, 0));
    check("r033_b_status", b_if.in_port, 8'h08);
    step(mk(CTL, 1, 0, 8'h02, 0), mk(CTL, 1, 0, 8'h02, 0));
    step(mk(STA, 0, 0, 8'h00, 0), mk(STA, 0, 0, 8'h00, 0));
    check("ctrl_clear_a", a_if.in_port, 8'h00);

    // Push into full FIFO while the far side pops
    do_reset();
    for (int i = 1; i <= 4; i++) step(mk(DAT, 1, 0, 8'(i), 0), idle());
    step(mk(DAT, 1, 0, 8'hAA, 0), mk(DAT, 0, 1, 8'h00, 0));
    check("r034_b_first", b_if.in_port, 8'h01);
    step(mk(STA, 0, 0, 8'h00, 0), mk(STA, 0, 0, 8'h00, 0));
    check("r034_a_status", a_if.in_port, 8'h02);
    check("r034_b_status", b_if.in_port, 8'h41);
    for (int i = 0; i < 4; i++) step(idle(), mk(DAT, 0, 1, 8'h00, 0));
    check("r034_b_last", b_if.in_port, 8'hAA);

    // Set wins over ack; ack alone clears; enabling with data pending raises irq
    do_reset();
    step(idle(), mk(CTL, 1, 0, 8'h01, 0));
    step(mk(DAT, 1, 0, 8'h01, 0), idle());
    step(mk(DAT, 1, 0, 8'h02, 0), mk(OFF, 0, 0, 8'h00, 1));
    check("r035_b_irq_kept", {7'b0, b_if.interrupt}, 8'h01);
    step(idle(), mk(OFF, 0, 0, 8'h00, 1));
    check("r035_b_irq_acked", {7'b0, b_if.interrupt}, 8'h00);
    step(idle(), mk(CTL, 1, 0, 8'h00, 0));
    step(idle(), mk(CTL, 1, 0, 8'h01, 0));
    check("r027_b_irq_enable", {7'b0, b_if.interrupt}, 8'h01);

    // Reset mid-transfer discards the queue
    do_reset();
    for (int i = 0; i < 3; i++) step(mk(DAT, 1, 0, 8'hC0 + 8'(i), 0), idle());
    do_reset();
    step(idle(), mk(STA, 0, 0, 8'h00, 0));
    check("r036_b_status", b_if.in_port, 8'h00);
    step(mk(DAT, 1, 0, 8'h33, 0), mk(DAT, 0, 0, 8'h00, 0));
    step(idle(), mk(DAT, 0, 1, 8'h00, 0));
    check("r036_b_data", b_if.in_port, 8'h33);

    // Wrap: interleaved push/pop over 3*DEPTH+1 words
    do_reset();
    step(mk(DAT, 1, 0, 8'h10, 0), idle());
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      step(mk(DAT, 1, 0, 8'h10 + 8'(i), 0), mk(DAT, 0, 1, 8'h00, 0));
      check("r037_order", b_if.in_port, 8'h10 + 8'(i - 1));
    end
    step(idle(), mk(DAT, 0, 1, 8'h00, 0));
    check("r037_last", b_if.in_port, 8'h10 + 8'(3 * DEPTH));
    step(mk(STA, 0, 0, 8'h00, 0), mk(STA, 0, 0, 8'h00, 0));
    check("r037_a_status", a_if.in_port, 8'h00);
    check("r037_b_status", b_if.in_port, 8'h00);

    // Random concurrent traffic on both sides
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op_t o [2];
      if ($urandom_range(0, 59) == 0) do_reset();
      for (int s = 0; s < 2; s++) begin
        int k;
        k = $urandom_range(0, 3);
        o[s] = mk(ids[$urandom_range(0, 5)], k == 1 || k == 3, k == 2, 8'($urandom),
                  $urandom_range(0, 3) == 0);
      end
      step(o[0], o[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pb_mailbox.md
PB_MAILBOX -- requirements
Module: pb_mailbox

Interface
REQ-001 Parameter DATA_W, default 8, data word width; SHALL be at least 8.
REQ-002 Parameter DEPTH, default 4, entries per direction FIFO; SHALL be a power of two, at least 2.
REQ-003 Parameter BASE, default 8'h00, port base address; bits [1:0] SHALL be ignored.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 a_port_id / b_port_id  in  8  side A / side B port address.
REQ-007 a_out_port / b_out_port  in  DATA_W  write data from side A / side B.
REQ-008 a_write_strobe / b_write_strobe  in  1  single-cycle write qualifier.
REQ-009 a_read_strobe / b_read_strobe  in  1  single-cycle read qualifier.
REQ-010 a_in_port / b_in_port  out  DATA_W  registered read data to side A / side B.
REQ-011 a_interrupt / b_interrupt  out  1  registered interrupt request.
REQ-012 a_interrupt_ack / b_interrupt_ack  in  1  interrupt acknowledge, clears the request.

Function
REQ-013 Two independent FIFOs of DEPTH x DATA_W SHALL exist: A->B, written by A and read by B; B->A, written by B and read by A.
REQ-014 A side SHALL be selected when port_id[7:2] == BASE[7:2]; offset = port_id[1:0]; 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
REQ-015 A write strobe to DATA SHALL push out_port into the side's TX FIFO at that edge if it is not full; if full, the data SHALL be dropped and sticky tx_ovf set.
REQ-016 A read strobe at DATA SHALL pop the side's RX FIFO at that edge if it is not empty; if empty, no pointer change and sticky rx_unf set.
REQ-017 x_in_port SHALL be registered every cycle from the current port_id decode: DATA gives the RX head (0 if empty), STATUS gives the status word, CTRL gives {0, irq_en}, reserved/unselected gives 0.
REQ-018 Read data SHALL be valid in the cycle after port_id settles; the pop at the read strobe edge SHALL take effect on the next in_port update.
REQ-019 STATUS bit0 = rx_not_empty, bit1 = tx_full, bit2 = tx_ovf, bit3 = rx_unf, bits[6:4] = min(rx_count, 7), bit7 and above = 0.
REQ-020 A CTRL write SHALL load irq_en from bit0; bit1 = 1 SHALL clear tx_ovf and rx_unf for the writing side only.
REQ-021 Writes to offset 3 or to STATUS SHALL be ignored.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; full = (count == DEPTH); empty = (count == 0).
REQ-023 A push into a full FIFO concurrent with a pop from it SHALL both occur, leaving count unchanged and clearing no flags.
REQ-024 A push into an empty FIFO concurrent with a read of it SHALL accept the push and flag rx_unf; the read returns 0.
REQ-025 x_interrupt SHALL set at the edge where a word is pushed into x's RX FIFO while x's irq_en = 1.
REQ-026 x_interrupt_ack SHALL clear x_interrupt; when set and ack coincide, set SHALL win.
REQ-027 Setting irq_en to 1 while RX is non-empty SHALL set x_interrupt on the next edge.
REQ-028 Both sides SHALL operate concurrently with no arbitration between them; each side's strobes affect only its own TX push, RX pop and flags.

Reset
REQ-029 On reset, all FIFO pointers and counts, tx_ovf, rx_unf, irq_en, x_interrupt and x_in_port SHALL be 0 on the next edge.
REQ-030 Reset SHALL override any concurrent strobe; FIFO contents need not be cleared but SHALL be unobservable (empty).
REQ-031 Reset mid-transfer SHALL discard all queued words; the first push after reset lands at entry 0.

Verification
REQ-032 Irq_en_B = 1; A writes 8'h5A to DATA -> b_interrupt = 1 next edge; B reads STATUS = 8'h11, reads DATA = 8'h5A; STATUS then = 8'h00.
REQ-033 A writes 5 words 01..05 with DEPTH = 4 -> A STATUS bit1 = 1 and bit2 = 1; B drains 01,02,03,04; a fifth read returns 0 and B bit3 = 1.
REQ-034 FIFO full; A push 8'hAA and B pop in the same cycle -> B receives 01, count stays 4, no tx_ovf; AA appears as the 4th subsequent word.
REQ-035 b_interrupt_ack concurrent with a new A push, irq_en_B = 1 -> b_interrupt remains 1.
REQ-036 Queue 3 words A->B, assert reset one cycle -> B STATUS = 8'h00, b_interrupt = 0; next A push 8'h33 is read back as 8'h33.
REQ-037 Wrap test: 3*DEPTH+1 interleaved push/pop with an incrementing pattern -> order preserved, no flags set.
